// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multicycle MIPS control path
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Shared with the ALU control decoder downstream.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/control_outputs.sv
// rtl/control_outputs.sv - combinational state-to-control decoder
module control_outputs
  import mips_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  // Everything defaults to 0; each state raises only what it needs.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = ALUSRCB_FOUR;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.irwrite  = mem_ready;
        ctrl.pcwrite  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb    = ALUSRCB_IMMSH;
        ctrl.aluop      = ALUOP_ADD;
        ctrl.illegal_op = ~op_supported(opcode);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg   = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite   = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_B;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = ALUSRCB_B;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
        ctrl.instr_done  = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcwrite    = 1'b1;
        ctrl.pcsource   = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main multicycle MIPS control FSM
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] ALUop,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  ctrl_t      ctrl;
  ctrl_t      ctrl_g;

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Latch the opcode in DECODE so later states ignore IR changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      op_q <= '0;
    else if (state_q == S_DECODE)   op_q <= opcode;
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    state_d = S_RWB;
      S_RWB:     state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ADDI_WB: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  control_outputs u_outputs (
    .state     (state_q),
    .mem_ready (mem_ready),
    .opcode    (opcode),
    .ctrl      (ctrl)
  );

  // Outputs are forced low for as long as reset is held, not just after the edge.
  assign ctrl_g = reset ? '0 : ctrl;

  assign ALUop       = ctrl_g.aluop;
  assign ALUSrcA     = ctrl_g.alusrca;
  assign ALUSrcB     = ctrl_g.alusrcb;
  assign PCSource    = ctrl_g.pcsource;
  assign PCWrite     = ctrl_g.pcwrite;
  assign PCWriteCond = ctrl_g.pcwritecond;
  assign IorD        = ctrl_g.iord;
  assign MemRead     = ctrl_g.memread;
  assign MemWrite    = ctrl_g.memwrite;
  assign IRWrite     = ctrl_g.irwrite;
  assign RegDst      = ctrl_g.regdst;
  assign MemtoReg    = ctrl_g.memtoreg;
  assign RegWrite    = ctrl_g.regwrite;
  assign instr_done  = ctrl_g.instr_done;
  assign illegal_op  = ctrl_g.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [1:0] ALUop;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, instr_done, illegal_op;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .ALUop       (ALUop),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ALUop, ALUSrcA, ALUSrcB, PCSource, flags}
  // flags: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite instr_done illegal_op
  logic [17:0] outs;
  assign outs = {ALUop, ALUSrcA, ALUSrcB, PCSource,
                 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                 RegDst, MemtoReg, RegWrite, instr_done, illegal_op};

  localparam logic [17:0] V_ZERO    = 18'd0;
  localparam logic [17:0] V_FETCH1  = {2'b00, 1'b0, 2'b01, 2'b00, 11'b10010100000};
  localparam logic [17:0] V_FETCH0  = {2'b00, 1'b0, 2'b01, 2'b00, 11'b00010000000};
  localparam logic [17:0] V_DECODE  = {2'b00, 1'b0, 2'b11, 2'b00, 11'b00000000000};
  localparam logic [17:0] V_DECILL  = {2'b00, 1'b0, 2'b11, 2'b00, 11'b00000000001};
  localparam logic [17:0] V_MEMADR  = {2'b00, 1'b1, 2'b10, 2'b00, 11'b00000000000};
  localparam logic [17:0] V_MEMRD   = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00110000000};
  localparam logic [17:0] V_MEMWB   = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00000001110};
  localparam logic [17:0] V_MEMWR0  = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00101000000};
  localparam logic [17:0] V_MEMWR1  = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00101000010};
  localparam logic [17:0] V_EXEC    = {2'b10, 1'b1, 2'b00, 2'b00, 11'b00000000000};
  localparam logic [17:0] V_RWB     = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00000010110};
  localparam logic [17:0] V_BRANCH  = {2'b01, 1'b1, 2'b00, 2'b01, 11'b01000000010};
  localparam logic [17:0] V_JUMP    = {2'b00, 1'b0, 2'b00, 2'b10, 11'b10000000010};
  localparam logic [17:0] V_ADDIEX  = {2'b00, 1'b1, 2'b10, 2'b00, 11'b00000000000};
  localparam logic [17:0] V_ADDIWB  = {2'b00, 1'b0, 2'b00, 2'b00, 11'b00000000110};

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle, check outputs mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic mr, input logic [17:0] exp);
    opcode    = op;
    mem_ready = mr;
    #1;
    check(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("reset_outs", outs, V_ZERO);
    @(posedge clk); #1;
    reset = 1'b0;

    // R-type, mem_ready ignored low in DECODE/EXEC
    cyc("r_fetch",  6'b000000, 1'b1, V_FETCH1);
    cyc("r_decode", 6'b000000, 1'b0, V_DECODE);
    cyc("r_exec",   6'b000000, 1'b0, V_EXEC);
    cyc("r_rwb",    6'b000000, 1'b1, V_RWB);

    // lw with two wait cycles in MEMRD
    cyc("lw_fetch",  6'b100011, 1'b1, V_FETCH1);
    cyc("lw_decode", 6'b100011, 1'b1, V_DECODE);
    cyc("lw_memadr", 6'b100011, 1'b1, V_MEMADR);
    cyc("lw_memrd0", 6'b100011, 1'b0, V_MEMRD);
    cyc("lw_memrd1", 6'b100011, 1'b0, V_MEMRD);
    cyc("lw_memrd2", 6'b100011, 1'b1, V_MEMRD);
    cyc("lw_memwb",  6'b100011, 1'b1, V_MEMWB);

    // sw with IR changing to R-type after DECODE
    cyc("sw_fetch",  6'b101011, 1'b1, V_FETCH1);
    cyc("sw_decode", 6'b101011, 1'b1, V_DECODE);
    cyc("sw_memadr", 6'b000000, 1'b1, V_MEMADR);
    cyc("sw_memwr0", 6'b000000, 1'b0, V_MEMWR0);
    cyc("sw_memwr1", 6'b000000, 1'b0, V_MEMWR0);
    cyc("sw_memwr2", 6'b000000, 1'b1, V_MEMWR1);

    // beq then j, with a fetch stall before the jump
    cyc("beq_fetch",  6'b000100, 1'b1, V_FETCH1);
    cyc("beq_decode", 6'b000100, 1'b1, V_DECODE);
    cyc("beq_branch", 6'b000100, 1'b0, V_BRANCH);
    cyc("j_fetch0",   6'b000010, 1'b0, V_FETCH0);
    cyc("j_fetch1",   6'b000010, 1'b1, V_FETCH1);
    cyc("j_decode",   6'b000010, 1'b1, V_DECODE);
    cyc("j_jump",     6'b000010, 1'b1, V_JUMP);

    // addi
    cyc("addi_fetch",  6'b001000, 1'b1, V_FETCH1);
    cyc("addi_decode", 6'b001000, 1'b1, V_DECODE);
    cyc("addi_ex",     6'b001000, 1'b1, V_ADDIEX);
    cyc("addi_wb",     6'b001000, 1'b1, V_ADDIWB);

    // illegal opcode: two cycles, back to FETCH
    cyc("ill_fetch",  6'b111111, 1'b1, V_FETCH1);
    cyc("ill_decode", 6'b111111, 1'b1, V_DECILL);
    cyc("ill_refetch", 6'b000000, 1'b0, V_FETCH0);
    cyc("ill_refetch1", 6'b000000, 1'b1, V_FETCH1);
    cyc("ill_after_decode", 6'b000000, 1'b1, V_DECODE);
    cyc("ill_after_exec", 6'b000000, 1'b1, V_EXEC);
    cyc("ill_after_rwb", 6'b000000, 1'b1, V_RWB);

    // reset asserted mid-MEMRD
    cyc("rst_fetch",  6'b100011, 1'b1, V_FETCH1);
    cyc("rst_decode", 6'b100011, 1'b1, V_DECODE);
    cyc("rst_memadr", 6'b100011, 1'b1, V_MEMADR);
    cyc("rst_memrd",  6'b100011, 1'b0, V_MEMRD);
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_async_outs", outs, V_ZERO);
    @(posedge clk); #1;
    check("rst_held_outs", outs, V_ZERO);
    reset = 1'b0;
    cyc("rst_post_fetch",  6'b101011, 1'b1, V_FETCH1);
    cyc("rst_post_decode", 6'b101011, 1'b1, V_DECODE);
    cyc("rst_post_memadr", 6'b101011, 1'b1, V_MEMADR);
    cyc("rst_post_memwr",  6'b101011, 1'b1, V_MEMWR1);
    cyc("rst_post_fetch2", 6'b000000, 1'b1, V_FETCH1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath, directly upstream of the ALU control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the 2-bit ALU operation class (00 add, 01 subtract for beq, 10 decode funct), the ALU operand selects and all datapath enables. Memory accesses stall on a ready handshake from the unified instruction/data memory.

## Interface
Parameters:
- none; all encodings are fixed in the shared package.

Ports:
- `clk`  in  1  single clock; all state changes occur on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces state to FETCH and all outputs to 0 while asserted.
- `opcode`  in  6  instruction bits [31:26], taken from the IR.
- `mem_ready`  in  1  memory access completes on the cycle this is high.
- `ALUop`  out  2  00 add, 01 subtract, 10 funct-decoded; feeds the ALU control decoder.
- `ALUSrcA`  out  1  0 = PC, 1 = register A.
- `ALUSrcB`  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegDst`, `MemtoReg`, `RegWrite`  out  1 each  standard multicycle datapath controls.
- `instr_done`  out  1  one-cycle pulse in the final state of every instruction.
- `illegal_op`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- Moore FSM: every output is a function of the current state, plus `mem_ready` where stated. Any signal not listed for a state is 0.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite and PCWrite equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target into ALUOut).
  - Registers `opcode` into op_q.
  - Next state from `opcode`:
    - 100011 (lw) or 101011 (sw): MEMADR.
    - 000000 (R-type): EXEC.
    - 000100 (beq): BRANCH.
    - 000010 (j): JUMP.
    - 001000 (addi): ADDI_EX.
    - Any other value: back to FETCH, with illegal_op=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Goes to MEMRD if op_q is lw, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Goes to FETCH.
- MEMWR:
  - MemWrite=1, IorD=1, held for the whole wait.
  - The write commits on the `mem_ready` cycle.
  - instr_done equals `mem_ready`. Goes to FETCH on `mem_ready`.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10. Goes to RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, instr_done=1. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Goes to FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUop=00. Goes to ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
- Boundary conditions:
  - MEMADR, MEMRD and MEMWR use op_q, never live `opcode`, so IR changes after DECODE are ignored.
  - `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.
  - Reset asserted mid-instruction: the instruction is abandoned and no further enables pulse. After release, the first cycle is FETCH.
  - Unused state encodings decode to FETCH with all outputs 0.

## Timing
- Registered state; outputs are combinational from state, with no added latency.
- Cycles per instruction with `mem_ready` held at 1:
  - lw: 5.
  - sw, R-type, addi: 4.
  - beq, j: 3.
  - Illegal opcode: 2.
- Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Reset values: state=FETCH, op_q=0, every output 0 while reset is high.
- FETCH outputs appear in the first cycle after reset deasserts.
- instr_done and illegal_op are never high in the same cycle.

## Structure
- Shared package `mips_pkg` holds:
  - The state typedef: 12 states, 4-bit encoding.
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - ALUop constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - The ALUSrcB and PCSource select constants.
  - The ALU control decoder uses the same ALUop constants.
- One sub-module, `control_outputs`: a purely combinational state-to-outputs decoder. The FSM top keeps only the state register, op_q and next-state logic.

## Test plan
- Reset asserted mid-MEMRD -> all outputs 0 immediately. After release: FETCH with MemRead=1 and IRWrite=1 (mem_ready=1).
- R-type (opcode 000000), mem_ready=1 -> sequence FETCH, DECODE, EXEC (ALUop=10), RWB (RegDst=1, RegWrite=1, instr_done=1); 4 cycles total.
- lw (100011), mem_ready low for 2 cycles in MEMRD -> 7 cycles total; MEMWB asserts MemtoReg=1 and RegWrite=1.
- sw (101011) with `opcode` changed to 000000 after DECODE -> still reaches MEMWR; MemWrite=1 held until mem_ready, then FETCH.
- beq (000100) then j (000010) -> BRANCH drives ALUop=01, PCWriteCond=1, PCSource=01; JUMP drives PCWrite=1, PCSource=10; 3 cycles each.
- opcode 111111 -> illegal_op pulse in DECODE, return to FETCH; no RegWrite, MemWrite or PCWrite outside FETCH.
